// File: rtl/jmp_pkg.sv
// Shared constants and the sequencer state type for the jump sequencer slice.
package jmp_pkg;

  localparam logic [3:0] OP_SUM  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MULT = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_ZERO   = 2'b01;
  localparam logic [1:0] COND_NZERO  = 2'b10;
  localparam logic [1:0] COND_NEVER  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/jmp_cond_eval.sv
// Combinational branch-condition evaluator: maps (cond, flag) to a taken bit.
module jmp_cond_eval
  import jmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       i_cond,
  input  logic [WIDTH-1:0] i_flag,
  output logic             o_taken
);

  always_comb begin
    o_taken = 1'b0;
    unique case (i_cond)
      COND_ALWAYS: o_taken = 1'b1;
      COND_ZERO:   o_taken = (i_flag == '0);
      COND_NZERO:  o_taken = (i_flag != '0);
      COND_NEVER:  o_taken = 1'b0;
      default:     o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/jump_sequencer.sv
// Three-state jump sequencer between decode, MiniALU and the fetch redirect.
// Optional divide-by-zero fault detection is enabled with `define JMP_DIV0_CHK_EN.
module jump_sequencer
  import jmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             FLUSH,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [OP_W-1:0]  REQ_OP,
  input  logic [WIDTH-1:0] REQ_BASE,
  input  logic [WIDTH-1:0] REQ_OFFSET,
  input  logic [1:0]       REQ_COND,
  input  logic [WIDTH-1:0] REQ_FLAG,
  input  logic [WIDTH-1:0] REQ_PC_NEXT,
  output logic             JMP_ENB,
  output logic [OP_W-1:0]  M_ALU_op,
  output logic [WIDTH-1:0] M_ALU_v1,
  output logic [WIDTH-1:0] M_ALU_v2,
  input  logic [WIDTH-1:0] M_ALU_out,
  output logic             RDR_VALID,
  input  logic             RDR_READY,
  output logic [WIDTH-1:0] RDR_TARGET,
  output logic             RDR_TAKEN,
  output logic             RDR_FAULT,
  output logic [CNT_W-1:0] TAKEN_CNT
);

  state_t           r_state;
  state_t           w_state_next;

  logic [OP_W-1:0]  r_op;
  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] r_offset;
  logic [1:0]       r_cond;
  logic [WIDTH-1:0] r_flag;
  logic [WIDTH-1:0] r_pc_next;

  logic [WIDTH-1:0] r_target;
  logic             r_taken;
  logic             r_fault;
  logic [CNT_W-1:0] r_cnt;

  logic             w_cond_taken;
  logic             w_div0;
  logic             w_issue;
  logic             w_accept;
  logic             w_rdr_fire;

  jmp_cond_eval #(
    .WIDTH (WIDTH)
  ) u_cond_eval (
    .i_cond  (r_cond),
    .i_flag  (r_flag),
    .o_taken (w_cond_taken)
  );

`ifdef JMP_DIV0_CHK_EN
  // A taken divide by zero is turned into a faulted fall-through instead of reaching the ALU.
  assign w_div0 = w_cond_taken && (r_op == OP_W'(OP_DIV)) && (r_offset == '0);
`else
  assign w_div0 = 1'b0;
`endif

  assign w_issue    = w_cond_taken && !w_div0;
  assign w_accept   = (r_state == IDLE) && REQ_VALID && !FLUSH;
  assign w_rdr_fire = (r_state == RESP) && RDR_READY && !FLUSH;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (FLUSH) begin
      w_state_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (REQ_VALID) w_state_next = EXEC;
        EXEC:    w_state_next = RESP;
        RESP:    if (RDR_READY) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    REQ_READY = 1'b0;
    JMP_ENB   = 1'b0;
    M_ALU_op  = '0;
    M_ALU_v1  = '0;
    M_ALU_v2  = '0;
    RDR_VALID = 1'b0;
    unique case (r_state)
      IDLE: REQ_READY = ~FLUSH;
      EXEC: begin
        if (w_issue) begin
          JMP_ENB  = 1'b1;
          M_ALU_op = r_op;
          M_ALU_v1 = r_base;
          M_ALU_v2 = r_offset;
        end
      end
      RESP:    RDR_VALID = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_op      <= '0;
      r_base    <= '0;
      r_offset  <= '0;
      r_cond    <= '0;
      r_flag    <= '0;
      r_pc_next <= '0;
    end else if (w_accept) begin
      r_op      <= REQ_OP;
      r_base    <= REQ_BASE;
      r_offset  <= REQ_OFFSET;
      r_cond    <= REQ_COND;
      r_flag    <= REQ_FLAG;
      r_pc_next <= REQ_PC_NEXT;
    end
  end

  // The redirect result is captured once in EXEC and then held through RESP.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_target <= '0;
      r_taken  <= 1'b0;
      r_fault  <= 1'b0;
    end else if ((r_state == EXEC) && !FLUSH) begin
      r_target <= w_issue ? M_ALU_out : r_pc_next;
      r_taken  <= w_issue;
      r_fault  <= w_div0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (w_rdr_fire && r_taken && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign RDR_TARGET = r_target;
  assign RDR_TAKEN  = r_taken;
  assign RDR_FAULT  = r_fault;
  assign TAKEN_CNT  = r_cnt;

endmodule

// File: tb/tb_jump_sequencer.sv
// Randomized self-checking bench for jump_sequencer against a transaction-level reference model.
// Expectations follow `define JMP_DIV0_CHK_EN when it is set for the build.
module tb_jump_sequencer;

  localparam int WIDTH   = 32;
  localparam int OP_W    = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK;
  logic             RST_N;
  logic             FLUSH;
  logic             REQ_VALID;
  logic             REQ_READY;
  logic [OP_W-1:0]  REQ_OP;
  logic [WIDTH-1:0] REQ_BASE;
  logic [WIDTH-1:0] REQ_OFFSET;
  logic [1:0]       REQ_COND;
  logic [WIDTH-1:0] REQ_FLAG;
  logic [WIDTH-1:0] REQ_PC_NEXT;
  logic             JMP_ENB;
  logic [OP_W-1:0]  M_ALU_op;
  logic [WIDTH-1:0] M_ALU_v1;
  logic [WIDTH-1:0] M_ALU_v2;
  logic [WIDTH-1:0] M_ALU_out;
  logic             RDR_VALID;
  logic             RDR_READY;
  logic [WIDTH-1:0] RDR_TARGET;
  logic             RDR_TAKEN;
  logic             RDR_FAULT;
  logic [CNT_W-1:0] TAKEN_CNT;

  int checks = 0;
  int errors = 0;
  int expCnt = 0;

  jump_sequencer #(
    .WIDTH (WIDTH),
    .OP_W  (OP_W),
    .CNT_W (CNT_W)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .FLUSH       (FLUSH),
    .REQ_VALID   (REQ_VALID),
    .REQ_READY   (REQ_READY),
    .REQ_OP      (REQ_OP),
    .REQ_BASE    (REQ_BASE),
    .REQ_OFFSET  (REQ_OFFSET),
    .REQ_COND    (REQ_COND),
    .REQ_FLAG    (REQ_FLAG),
    .REQ_PC_NEXT (REQ_PC_NEXT),
    .JMP_ENB     (JMP_ENB),
    .M_ALU_op    (M_ALU_op),
    .M_ALU_v1    (M_ALU_v1),
    .M_ALU_v2    (M_ALU_v2),
    .M_ALU_out   (M_ALU_out),
    .RDR_VALID   (RDR_VALID),
    .RDR_READY   (RDR_READY),
    .RDR_TARGET  (RDR_TARGET),
    .RDR_TAKEN   (RDR_TAKEN),
    .RDR_FAULT   (RDR_FAULT),
    .TAKEN_CNT   (TAKEN_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // MiniALU behaviour; a zero divisor yields 0.
  function automatic logic [WIDTH-1:0] aluRef(input logic [OP_W-1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] prod;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: begin prod = a * b; return prod[WIDTH-1:0]; end
      4'd3: return (b == 0) ? '0 : a / b;
      4'd4: return a & b;
      4'd5: return a | b;
      4'd6: return a ^ b;
      default: return '0;
    endcase
  endfunction

  function automatic bit condRef(input logic [1:0] cond, input logic [WIDTH-1:0] flag);
    if (cond == 2'b00) return 1'b1;
    if (cond == 2'b01) return flag == 0;
    if (cond == 2'b10) return flag != 0;
    return 1'b0;
  endfunction

  function automatic bit div0Ref(input logic [OP_W-1:0] op, input logic [WIDTH-1:0] offset);
`ifdef JMP_DIV0_CHK_EN
    return (op == 4'd3) && (offset == 0);
`else
    return 1'b0;
`endif
  endfunction

  always_comb M_ALU_out = aluRef(M_ALU_op, M_ALU_v1, M_ALU_v2);

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full request: issue, EXEC, RESP with readyDelay stalled cycles, then handshake or flush.
  task automatic applyStimulus(input logic [OP_W-1:0] op, input logic [WIDTH-1:0] base,
                               input logic [WIDTH-1:0] offset, input logic [1:0] cond,
                               input logic [WIDTH-1:0] flag, input logic [WIDTH-1:0] pcNext,
                               input int readyDelay, input bit flushResp);
    bit condOk, fault, issue;
    logic [WIDTH-1:0] expTarget;
    condOk    = condRef(cond, flag);
    fault     = condOk && div0Ref(op, offset);
    issue     = condOk && !fault;
    expTarget = issue ? aluRef(op, base, offset) : pcNext;

    @(negedge CLK);
    REQ_OP = op; REQ_BASE = base; REQ_OFFSET = offset;
    REQ_COND = cond; REQ_FLAG = flag; REQ_PC_NEXT = pcNext;
    REQ_VALID = 1'b1; RDR_READY = 1'b0;
    checkOutput("req_ready_idle", 64'(REQ_READY), 64'd1);

    @(negedge CLK);
    REQ_VALID = 1'b0;
    REQ_OP = OP_W'($urandom); REQ_BASE = $urandom; REQ_OFFSET = $urandom;
    REQ_COND = 2'($urandom); REQ_FLAG = $urandom; REQ_PC_NEXT = $urandom;
    checkOutput("jmp_enb_exec", 64'(JMP_ENB), 64'(issue));
    checkOutput("alu_op_exec", 64'(M_ALU_op), issue ? 64'(op) : 64'd0);
    checkOutput("alu_v1_exec", 64'(M_ALU_v1), issue ? 64'(base) : 64'd0);
    checkOutput("alu_v2_exec", 64'(M_ALU_v2), issue ? 64'(offset) : 64'd0);
    checkOutput("rdr_valid_exec", 64'(RDR_VALID), 64'd0);
    checkOutput("req_ready_exec", 64'(REQ_READY), 64'd0);

    @(negedge CLK);
    for (int i = 0; i <= readyDelay; i++) begin
      checkOutput("rdr_valid_resp", 64'(RDR_VALID), 64'd1);
      checkOutput("rdr_target", 64'(RDR_TARGET), 64'(expTarget));
      checkOutput("rdr_taken", 64'(RDR_TAKEN), 64'(issue));
      checkOutput("rdr_fault", 64'(RDR_FAULT), 64'(fault));
      checkOutput("jmp_enb_resp", 64'(JMP_ENB), 64'd0);
      checkOutput("req_ready_resp", 64'(REQ_READY), 64'd0);
      if (i < readyDelay) @(negedge CLK);
    end

    RDR_READY = 1'b1;
    if (flushResp) begin
      FLUSH = 1'b1;
      @(negedge CLK);
      checkOutput("flush_rdr_valid", 64'(RDR_VALID), 64'd0);
      checkOutput("flush_req_ready", 64'(REQ_READY), 64'd0);
      FLUSH = 1'b0; RDR_READY = 1'b0;
      #1;
      checkOutput("post_flush_ready", 64'(REQ_READY), 64'd1);
    end else begin
      @(negedge CLK);
      RDR_READY = 1'b0;
      if (issue && expCnt != CNT_MAX) expCnt++;
      checkOutput("post_hs_valid", 64'(RDR_VALID), 64'd0);
      checkOutput("post_hs_ready", 64'(REQ_READY), 64'd1);
    end
    checkOutput("taken_cnt", 64'(TAKEN_CNT), 64'(expCnt));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [OP_W-1:0]  rOp;
    logic [WIDTH-1:0] rOff, rFlag;

    RST_N = 1'b0; FLUSH = 1'b0; REQ_VALID = 1'b0; RDR_READY = 1'b0;
    REQ_OP = '0; REQ_BASE = '0; REQ_OFFSET = '0; REQ_COND = '0; REQ_FLAG = '0; REQ_PC_NEXT = '0;
    #3;
    checkOutput("rst_req_ready", 64'(REQ_READY), 64'd1);
    checkOutput("rst_jmp_enb", 64'(JMP_ENB), 64'd0);
    checkOutput("rst_rdr_valid", 64'(RDR_VALID), 64'd0);
    checkOutput("rst_target", 64'(RDR_TARGET), 64'd0);
    checkOutput("rst_cnt", 64'(TAKEN_CNT), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    $display("[TB] directed requests");
    applyStimulus(4'd0, 32'h1000, 32'h20, 2'b00, 32'h0, 32'h4, 0, 1'b0);
    checkOutput("first_target_cnt", 64'(TAKEN_CNT), 64'd1);
    applyStimulus(4'd1, 32'h10, 32'h20, 2'b01, 32'h5, 32'h44, 0, 1'b0);
    applyStimulus(4'd2, 32'h12345, 32'h777, 2'b10, 32'h1, 32'h88, 5, 1'b0);
    applyStimulus(4'd5, 32'hF0F0, 32'h0F00, 2'b00, 32'h0, 32'h90, 1, 1'b1);
    applyStimulus(4'd9, 32'hDEAD, 32'hBEEF, 2'b00, 32'h0, 32'hA0, 0, 1'b0);
    applyStimulus(4'd4, 32'hFFFF, 32'h1, 2'b11, 32'h0, 32'hB0, 0, 1'b0);
    applyStimulus(4'd3, 32'h1234, 32'h0, 2'b00, 32'h0, 32'h80, 0, 1'b0);
    applyStimulus(4'd0, 32'hFFFF_FFF0, 32'h20, 2'b00, 32'h0, 32'hC0, 0, 1'b0);

    $display("[TB] random requests");
    for (int n = 0; n < 60; n++) begin
      rOp   = OP_W'($urandom_range(0, 15));
      rOff  = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      rFlag = ($urandom_range(0, 1) == 0) ? '0 : $urandom;
      applyStimulus(rOp, $urandom, rOff, 2'($urandom), rFlag, $urandom,
                    $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
    end

    $display("[TB] reset during EXEC");
    @(negedge CLK);
    REQ_OP = 4'd0; REQ_BASE = 32'h100; REQ_OFFSET = 32'h4; REQ_COND = 2'b00;
    REQ_FLAG = '0; REQ_PC_NEXT = 32'h8; REQ_VALID = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    checkOutput("pre_rst_enb", 64'(JMP_ENB), 64'd1);
    #2 RST_N = 1'b0;
    #1;
    checkOutput("mid_rst_enb", 64'(JMP_ENB), 64'd0);
    checkOutput("mid_rst_v1", 64'(M_ALU_v1), 64'd0);
    checkOutput("mid_rst_valid", 64'(RDR_VALID), 64'd0);
    checkOutput("mid_rst_target", 64'(RDR_TARGET), 64'd0);
    checkOutput("mid_rst_cnt", 64'(TAKEN_CNT), 64'd0);
    checkOutput("mid_rst_ready", 64'(REQ_READY), 64'd1);
    expCnt = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    checkOutput("no_rdr_after_rst", 64'(RDR_VALID), 64'd0);

    $display("[TB] counter saturation");
    for (int n = 0; n < CNT_MAX - 1; n++) begin
      applyStimulus(4'd0, $urandom, $urandom, 2'b00, $urandom, $urandom, 0, 1'b0);
    end
    checkOutput("cnt_preload", 64'(TAKEN_CNT), 64'(CNT_MAX - 1));
    for (int n = 0; n < 3; n++) begin
      applyStimulus(4'd6, $urandom, $urandom, 2'b00, $urandom, $urandom, 0, 1'b0);
    end
    checkOutput("cnt_saturated", 64'(TAKEN_CNT), 64'(CNT_MAX));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
